// File: rtl/message_scroller_pkg.sv
// Shared types, sizes and default message contents for the message scroller.
// Build option: SCROLL_DIR_EN adds a reverse-scroll dir input to the top.
package message_scroller_pkg;

  localparam int MSG_DEPTH = 16;
  localparam int CHAR_W    = 4;
  localparam int PTR_W     = 4;
  localparam int PRESC_W   = 16;

  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWELL = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Four visible digits, c3 drives an3 (leftmost).
  typedef struct packed {
    char_t c3;
    char_t c2;
    char_t c1;
    char_t c0;
  } window_t;

  // Power-up message is the identity ramp 0,1,..,F.
  function automatic char_t default_char(input ptr_t idx);
    return char_t'(idx);
  endfunction

  function automatic window_t default_window(input ptr_t start);
    window_t w;
    w.c3 = default_char(start);
    w.c2 = default_char(start + ptr_t'(1));
    w.c1 = default_char(start + ptr_t'(2));
    w.c0 = default_char(start + ptr_t'(3));
    return w;
  endfunction

endpackage

// File: rtl/message_scroller_if.sv
// Control, write and display-window signals of the message scroller.
// The scroller itself takes the slave side; the driver/bench takes master.
interface message_scroller_if;
  import message_scroller_pkg::*;

  logic  enable;
  logic  wr_en;
  ptr_t  wr_addr;
  char_t wr_char;
  char_t char3;
  char_t char2;
  char_t char1;
  char_t char0;
  ptr_t  ptr;
  logic  step;

  modport master (
    output enable, wr_en, wr_addr, wr_char,
    input  char3, char2, char1, char0, ptr, step
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_char,
    output char3, char2, char1, char0, ptr, step
  );

endinterface

// File: rtl/scroll_timer.sv
// Step prescaler plus dwell counter; tc is a combinational terminal-count pulse.
// Both counters freeze while run is low; the dwell count is also cleared then.
module scroll_timer
  import message_scroller_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned DWELL_STEPS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic dwell,
  output logic tc,
  output logic dwell_done
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYCLES - 1);
  localparam logic [PRESC_W-1:0] DWELL_LAST =
    PRESC_W'((DWELL_STEPS > 0) ? (DWELL_STEPS - 1) : 0);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] dwell_q;

  assign tc         = run && (presc_q == PRESC_LAST);
  assign dwell_done = dwell && tc && (dwell_q == DWELL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      dwell_q <= '0;
    end else begin
      if (run) begin
        presc_q <= tc ? '0 : presc_q + PRESC_W'(1);
      end
      // A pause abandons any dwell in progress.
      if (!run || dwell_done) begin
        dwell_q <= '0;
      end else if (dwell && tc) begin
        dwell_q <= dwell_q + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/message_scroller.sv
// 16x4 message memory shown through a registered 4-char window that scrolls every STEP_CYCLES.
// Build option SCROLL_DIR_EN adds input dir (1 = scroll backwards); default build scrolls forward.
module message_scroller
  import message_scroller_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned DWELL_STEPS = 2
) (
  input  logic clk,
  input  logic reset,
`ifdef SCROLL_DIR_EN
  input  logic dir,
`endif
  message_scroller_if.slave bus
);

  localparam bit DWELL_ON = (DWELL_STEPS != 0);

  state_t  state_q;
  state_t  state_d;
  ptr_t    ptr_q;
  ptr_t    ptr_d;
  logic    step_q;
  logic    step_d;
  char_t   msg_q [MSG_DEPTH];
  window_t win_q;

  logic    tc;
  logic    dwell_done;
  logic    reverse;
  ptr_t    ptr_adv;
  logic    wraps;

`ifdef SCROLL_DIR_EN
  assign reverse = dir;
`else
  assign reverse = 1'b0;
`endif

  assign ptr_adv = reverse ? (ptr_q - ptr_t'(1)) : (ptr_q + ptr_t'(1));
  assign wraps   = reverse ? (ptr_q == '0) : (ptr_q == '1);

  scroll_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .DWELL_STEPS (DWELL_STEPS)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .run        (bus.enable),
    .dwell      (state_q == ST_DWELL),
    .tc         (tc),
    .dwell_done (dwell_done)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    step_d  = 1'b0;
    if (!bus.enable) begin
      state_d = ST_PAUSE;
    end else begin
      case (state_q)
        ST_DWELL: begin
          if (dwell_done) begin
            state_d = ST_RUN;
          end
        end
        // RUN, and PAUSE resuming: the resume edge already counts as an enabled cycle.
        default: begin
          state_d = ST_RUN;
          if (tc) begin
            step_d = 1'b1;
            ptr_d  = ptr_adv;
            if (wraps && DWELL_ON) begin
              state_d = ST_DWELL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg_q[i] <= default_char(ptr_t'(i));
      end
    end else if (bus.wr_en) begin
      msg_q[bus.wr_addr] <= bus.wr_char;
    end
  end

  // Window trails ptr/memory by one cycle, so a write landing with a step shows together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= default_window('0);
    end else begin
      win_q.c3 <= msg_q[ptr_q];
      win_q.c2 <= msg_q[ptr_q + ptr_t'(1)];
      win_q.c1 <= msg_q[ptr_q + ptr_t'(2)];
      win_q.c0 <= msg_q[ptr_q + ptr_t'(3)];
    end
  end

  assign bus.char3 = win_q.c3;
  assign bus.char2 = win_q.c2;
  assign bus.char1 = win_q.c1;
  assign bus.char0 = win_q.c0;
  assign bus.ptr   = ptr_q;
  assign bus.step  = step_q;

endmodule

// File: tb/tb_message_scroller.sv
// Directed plus randomized bench for message_scroller against a cycle-level behavioural model.
// Model tracks prescaler, remaining dwell steps, pointer, memory and the lagged window.
module tb_message_scroller;

  localparam int SC = 4;
  localparam int DS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef SCROLL_DIR_EN
  logic dir;
`endif

  message_scroller_if bus ();

  message_scroller #(
    .STEP_CYCLES (SC),
    .DWELL_STEPS (DS)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SCROLL_DIR_EN
    .dir   (dir),
`endif
    .bus   (bus)
  );

  int checks;
  int errors;

  int m_presc;
  int m_dwell_left;
  int m_ptr;
  int m_step;
  int m_msg [16];
  int m_win [4];

  task automatic model_reset();
    m_presc      = 0;
    m_dwell_left = 0;
    m_ptr        = 0;
    m_step       = 0;
    for (int k = 0; k < 16; k++) m_msg[k] = k;
    for (int k = 0; k < 4; k++) m_win[k] = k;
  endtask

  // One rising edge: window shows pre-edge memory/pointer; writes and steps land together.
  task automatic model_edge(input bit en, input bit we, input int wa, input int wc, input bit d);
    int old;
    for (int k = 0; k < 4; k++) m_win[k] = m_msg[(m_ptr + k) % 16];
    m_step = 0;
    if (!en) begin
      m_dwell_left = 0;
    end else if (m_presc == SC - 1) begin
      m_presc = 0;
      if (m_dwell_left > 0) begin
        m_dwell_left--;
      end else begin
        old    = m_ptr;
        m_ptr  = d ? (m_ptr + 15) % 16 : (m_ptr + 1) % 16;
        m_step = 1;
        if (DS > 0 && (d ? (old == 0) : (old == 15))) m_dwell_left = DS;
      end
    end else begin
      m_presc++;
    end
    if (we) m_msg[wa] = wc;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".step"},  8'(bus.step),  8'(m_step));
    chk({tag, ".ptr"},   8'(bus.ptr),   8'(m_ptr));
    chk({tag, ".char3"}, 8'(bus.char3), 8'(m_win[0]));
    chk({tag, ".char2"}, 8'(bus.char2), 8'(m_win[1]));
    chk({tag, ".char1"}, 8'(bus.char1), 8'(m_win[2]));
    chk({tag, ".char0"}, 8'(bus.char0), 8'(m_win[3]));
  endtask

  task automatic tick(input string tag);
    bit d;
    d = 1'b0;
`ifdef SCROLL_DIR_EN
    d = dir;
`endif
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(bus.enable, bus.wr_en, int'(bus.wr_addr), int'(bus.wr_char), d);
    #1;
    check_all(tag);
  endtask

  int n;
  int stepcnt;
  int held [4];

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.enable  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_char = '0;
`ifdef SCROLL_DIR_EN
    dir = 1'b0;
`endif
    model_reset();
    #1 reset = 1'b0;
    #2;
    check_all("reset");
    repeat (2) tick("in_reset");
    reset = 1'b1;

    // Default-parameter start-up: steps at 4, 8, 12.
    bus.enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick("startup");
      if (i % 4 == 0) begin
        chk("startup.step_pulse", 8'(bus.step), 8'd1);
        chk("startup.ptr_value", 8'(bus.ptr), 8'(i / 4));
      end
      if (i == 5) begin
        chk("startup.c3", 8'(bus.char3), 8'd1);
        chk("startup.c2", 8'(bus.char2), 8'd2);
        chk("startup.c1", 8'(bus.char1), 8'd3);
        chk("startup.c0", 8'(bus.char0), 8'd4);
      end
    end

    // Async reset in the middle of a RUN cycle at ptr 7.
    n = 0;
    while (m_ptr != 7 && n < 100) begin tick("to_ptr7"); n++; end
    chk("bound.to_ptr7", 8'(n < 100), 8'd1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("midreset.ptr", 8'(bus.ptr), 8'd0);
    chk("midreset.step", 8'(bus.step), 8'd0);
    chk("midreset.c3", 8'(bus.char3), 8'd0);
    chk("midreset.c0", 8'(bus.char0), 8'd3);
    check_all("midreset");
    tick("midreset_edge");
    reset = 1'b1;

    // Write slot 1 on the same edge as the 0->1 step.
    repeat (3) tick("pre_write");
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_char = 4'd9;
    tick("write_step");
    bus.wr_en = 1'b0;
    chk("wstep.ptr", 8'(bus.ptr), 8'd1);
    tick("write_show");
    chk("wshow.c3", 8'(bus.char3), 8'd9);
    chk("wshow.c2", 8'(bus.char2), 8'd2);
    chk("wshow.c1", 8'(bus.char1), 8'd3);
    chk("wshow.c0", 8'(bus.char0), 8'd4);

    // Wrap 15 -> 0 then dwell two step periods.
    n = 0;
    while (!(m_step == 1 && m_ptr == 0) && n < 200) begin tick("to_wrap"); n++; end
    chk("bound.to_wrap", 8'(n < 200), 8'd1);
    stepcnt = 0;
    for (int i = 0; i < 11; i++) begin
      tick("dwell");
      stepcnt += int'(bus.step);
    end
    chk("dwell.quiet", 8'(stepcnt), 8'd0);
    chk("dwell.ptr_held", 8'(bus.ptr), 8'd0);
    tick("post_dwell");
    chk("postdwell.step", 8'(bus.step), 8'd1);
    chk("postdwell.ptr", 8'(bus.ptr), 8'd1);

    // Pause with the prescaler at 2, then resume.
    n = 0;
    while (m_presc != 2 && n < 10) begin tick("to_presc2"); n++; end
    chk("bound.to_presc2", 8'(n < 10), 8'd1);
    bus.enable = 1'b0;
    repeat (10) begin
      tick("pause");
      chk("pause.ptr_held", 8'(bus.ptr), 8'd1);
    end
    bus.enable = 1'b1;
    tick("resume1");
    chk("resume1.step", 8'(bus.step), 8'd0);
    tick("resume2");
    chk("resume2.step", 8'(bus.step), 8'd1);
    chk("resume2.ptr", 8'(bus.ptr), 8'd2);

    // Write far outside the window while paused: window must not move.
    bus.enable = 1'b0;
    repeat (2) tick("hold");
    for (int k = 0; k < 4; k++) held[k] = m_win[k];
    bus.wr_en = 1'b1; bus.wr_addr = 4'((m_ptr + 8) % 16); bus.wr_char = 4'hE;
    tick("far_write");
    bus.wr_en = 1'b0;
    tick("far_show");
    chk("far.c3", 8'(bus.char3), 8'(held[0]));
    chk("far.c0", 8'(bus.char0), 8'(held[3]));

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bus.enable  = ($urandom_range(0, 9) != 0);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_char = 4'($urandom_range(0, 15));
`ifdef SCROLL_DIR_EN
      if (i % 64 == 0) dir = 1'($urandom_range(0, 1));
`endif
      tick("random");
    end
    bus.wr_en = 1'b0;

`ifdef SCROLL_DIR_EN
    // Reverse scroll from reset: first step wraps to 15 and dwells.
    reset = 1'b0;
    dir = 1'b1;
    model_reset();
    tick("rev_reset");
    reset = 1'b1;
    bus.enable = 1'b1;
    repeat (4) tick("rev");
    chk("rev.step", 8'(bus.step), 8'd1);
    chk("rev.ptr", 8'(bus.ptr), 8'd15);
    tick("rev_show");
    chk("rev.c3", 8'(bus.char3), 8'd15);
    chk("rev.c2", 8'(bus.char2), 8'd0);
    chk("rev.c1", 8'(bus.char1), 8'd1);
    chk("rev.c0", 8'(bus.char0), 8'd2);
    repeat (12) tick("rev_dwell");
    dir = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/message_scroller.md
MESSAGE_SCROLLER -- requirements
Module: message_scroller

Interface
REQ-001 Parameter STEP_CYCLES, default 4, means clk cycles per scroll step; legal range 2..65535.
REQ-002 Parameter DWELL_STEPS, default 2, means scroll steps to hold after the window wraps to position 0; 0 disables the dwell.
REQ-003 Port clk  input  1  is the single clock; all state is on its rising edge.
REQ-004 Port reset  input  1  is the asynchronous, active-low reset.
REQ-005 Port enable  input  1  is the scroll run request; low pauses scrolling.
REQ-006 Port wr_en  input  1  is the message write strobe, sampled on the clk edge.
REQ-007 Port wr_addr  input  4  is the message slot to write.
REQ-008 Port wr_char  input  4  is the character code to write.
REQ-009 Port char3, char2, char1, char0  output  4 each  carry the characters for digits an3..an0 to the display multiplexer.
REQ-010 Port ptr  output  4  is the current window start index.
REQ-011 Port step  output  1  is a one-cycle pulse on each pointer advance.

Function
REQ-012 The block SHALL hold a 16-entry x 4-bit message memory, written when wr_en=1 at msg[wr_addr] <= wr_char.
REQ-013 Window outputs SHALL be registered, with char3=msg[ptr], char2=msg[ptr+1], char1=msg[ptr+2], char0=msg[ptr+3], indices mod 16, valid one cycle after any ptr or memory change.
REQ-014 The FSM SHALL have three states: RUN, DWELL and PAUSE.
REQ-015 In RUN, the prescaler SHALL count 0..STEP_CYCLES-1; at the terminal count it SHALL wrap to 0, pulse step for one cycle, and set ptr <= ptr+1 mod 16.
REQ-016 When a step makes ptr wrap from 15 to 0 and DWELL_STEPS>0, the FSM SHALL enter DWELL; otherwise it SHALL stay in RUN.
REQ-017 In DWELL, the prescaler SHALL keep running, step SHALL stay low, ptr SHALL hold, and the dwell counter SHALL count terminal counts; after DWELL_STEPS terminal counts the FSM SHALL return to RUN.
REQ-018 With enable=0 in RUN or DWELL, the FSM SHALL go to PAUSE on the next edge, hold the prescaler and ptr, and clear the dwell counter.
REQ-019 In PAUSE with enable=1, the FSM SHALL go to RUN, and the prescaler SHALL resume from its held value.
REQ-020 A write coinciding with a step SHALL take effect, and the next-cycle window SHALL reflect both the write and the new ptr.
REQ-021 A write to a slot outside the current window SHALL leave char3..char0 unchanged.

Reset
REQ-022 While reset=0: FSM=RUN, prescaler=0, dwell counter=0, ptr=0, step=0, msg[i]=i for i=0..15, char3..char0=0,1,2,3.
REQ-023 Reset asserted mid-operation SHALL force REQ-022 values immediately, independent of clk.
REQ-024 After reset is released, the first step SHALL occur STEP_CYCLES enabled cycles later.

Configuration
REQ-025 With SCROLL_DIR_EN defined, an input port dir (1 bit) SHALL exist; dir=1 makes each step ptr <= ptr-1 mod 16, and the dwell then triggers on the wrap from 0 to 15.
REQ-026 Without SCROLL_DIR_EN, the dir port SHALL be absent and scrolling SHALL always be forward.

Structure
REQ-027 A shared package SHALL hold the state encodings RUN/DWELL/PAUSE, the message depth 16, the char width 4 and the default message contents.
REQ-028 The prescaler plus dwell counter SHALL form one sub-module, scroll_timer, which outputs a terminal-count pulse.

Verification
REQ-029 Reset, then enable=1 with defaults -> step pulses at cycles 4, 8, 12; ptr goes 1,2,3; chars read 1,2,3,4 one cycle after the first step.
REQ-030 Run to ptr=15, then the next step -> ptr=0, no step pulses for the next 8 cycles (DWELL), then ptr=1.
REQ-031 Drop enable at prescaler=2 for 10 cycles, then raise it -> the next step occurs 2 enabled cycles later; ptr is unchanged during the pause.
REQ-032 Write wr_addr=1, wr_char=9 in the same cycle as the step from ptr=0 to 1 -> the next cycle shows char3=9, char2=2, char1=3, char0=4.
REQ-033 Assert reset at ptr=7 during DWELL-free RUN -> ptr=0 and chars=0,1,2,3 immediately; step stays low.
REQ-034 With SCROLL_DIR_EN and dir=1 from reset -> the first step gives ptr=15 and enters DWELL; chars read F,0,1,2.
